cache_ram_arbiter: RTL and testbench
====================================

CACHE_RAM_ARBITER -- requirements
Module: cache_ram_arbiter

Interface
REQ-001 SHALL have one clock and one reset: the clock is CLK, and nRST is an asynchronous, active-low reset.
REQ-002 SHALL expose the following ports (name, direction, width, meaning):
- CLK  in  1  clock.
- nRST  in  1  async active-low reset.
- bank_REN  in  NUM_BANKS  per-bank read request.
- bank_WEN  in  NUM_BANKS  per-bank write request.
- bank_addr  in  NUM_BANKS x 32  per-bank word address.
- bank_store  in  NUM_BANKS x CACHE_RW_SIZE  per-bank write data.
- bank_load  out  CACHE_RW_SIZE  RAM read data, broadcast to all banks.
- bank_complete  out  NUM_BANKS  per-bank completion strobe.
- ram_REN  out  1  to RAM.
- ram_WEN  out  1  to RAM.
- ram_addr  out  32  to RAM.
- ram_store  out  CACHE_RW_SIZE  to RAM.
- ram_load  in  CACHE_RW_SIZE  from RAM.
- ram_complete  in  1  from RAM.
- grant_valid  out  1  a bank owns the RAM.
- grant_id  out  BANKS_LEN  index of the owning bank.
- protocol_err  out  1  one-cycle error pulse.

Function
REQ-003 SHALL implement a two-state FSM: ARB_IDLE and ARB_OWNED.
REQ-004 ARB_IDLE: if any bank_REN|bank_WEN is set, SHALL select a winner by round robin, searching from rr_ptr+1 upward with wrap. The winner is registered into grant_id, and the FSM moves to ARB_OWNED on the next edge.
REQ-005 ARB_IDLE: ram_REN, ram_WEN, ram_addr, ram_store, bank_complete and grant_valid SHALL all be 0.
REQ-006 Grant latency SHALL be exactly 1 cycle: a request first seen in ARB_IDLE at cycle N drives the RAM from cycle N+1.
REQ-007 ARB_OWNED: SHALL combinationally forward the granted bank's REN, WEN, addr and store to the RAM, and set grant_valid to 1.
REQ-008 ARB_OWNED: bank_complete[grant_id] SHALL equal ram_complete; all other bank_complete bits SHALL be 0.
REQ-009 bank_load SHALL equal ram_load in all states.
REQ-010 Grant SHALL be held while the granted bank keeps REN|WEN set. A REN-to-WEN handoff in consecutive cycles (block pull followed by victim eject) SHALL NOT release the grant.
REQ-011 Release: in the first ARB_OWNED cycle in which the granted bank has REN=WEN=0:
- RAM outputs SHALL be 0.
- rr_ptr SHALL be loaded with grant_id.
- The FSM SHALL move to ARB_IDLE.
REQ-012 One ARB_IDLE cycle SHALL always separate consecutive grants; there is no back-to-back re-grant.
REQ-013 Requests from non-granted banks SHALL be held off without loss: they receive no complete and stay pending until arbitration.
REQ-014 If the granted bank asserts REN and WEN together, the arbiter SHALL forward only ram_REN and pulse protocol_err.
REQ-015 If ram_complete arrives in ARB_IDLE or in a release cycle, it SHALL NOT be forwarded, and protocol_err SHALL pulse.
REQ-016 grant_id SHALL hold its last value in ARB_IDLE. Consumers SHALL qualify grant_id with grant_valid.

Reset
REQ-017 On nRST low:
- state SHALL be ARB_IDLE.
- rr_ptr SHALL be NUM_BANKS-1, so bank 0 has first priority.
- grant_id SHALL be 0.
- protocol_err SHALL be 0.
- All outputs SHALL be 0.
REQ-018 Reset mid-burst SHALL drop the grant immediately and asynchronously, with ram_REN and ram_WEN at 0. Banks re-request after reset.

Structure
REQ-019 NUM_BANKS (2**BANKS_LEN) and the enum arb_state_t {ARB_IDLE, ARB_OWNED} SHALL reside in cache_types_pkg. CACHE_RW_SIZE and BANKS_LEN SHALL be reused from that package.
REQ-020 Winner selection SHALL be a combinational sub-module, rr_picker, with inputs req[NUM_BANKS] and ptr[BANKS_LEN] and outputs valid and idx[BANKS_LEN].

Verification
REQ-021 Reset, then bank 0 holds REN for 4 reads with ram_complete each cycle, then drops REN -> grant_valid=1 from cycle 1 to 4; bank_complete=0001 four times; FSM returns to ARB_IDLE at cycle 5.
REQ-022 Banks 1 and 2 request together after reset -> bank 1 is granted first; bank 2 is granted one idle cycle after bank 1 releases; bank 2 sees no complete while waiting.
REQ-023 Bank 3 issues 4 REN immediately followed by 4 WEN to addr 0x100-0x10C -> a single grant covers all 8 transfers; ram_store equals bank_store[3] during the WEN phase.
REQ-024 All banks request continuously, each releasing after 1 transfer -> grant order is 0,1,2,3,0 (NUM_BANKS=4).
REQ-025 Granted bank asserts REN and WEN together -> protocol_err=1 for that cycle, ram_WEN=0. A stray ram_complete in ARB_IDLE -> protocol_err=1, bank_complete=0.
REQ-026 nRST low during bank 2's 2nd transfer -> ram_REN=0 immediately; after reset, bank 2 (sole requester) is re-granted with 1-cycle latency.

Source files
------------

// File: rtl/cache_types_pkg.sv
// Shared cache-side types and sizes used by the RAM arbiter and its picker.
package cache_types_pkg;

    localparam int BANKS_LEN     = 2;
    localparam int NUM_BANKS     = 2 ** BANKS_LEN;
    localparam int CACHE_RW_SIZE = 32;

    // ARB_IDLE: nobody owns the RAM; ARB_OWNED: grant_id owns the RAM.
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cache_ram_arbiter_rr_picker.sv
// Combinational round-robin winner selection: the search starts at ptr+1 and
// wraps, so the bank at ptr itself has the lowest priority.
module rr_picker
    import cache_types_pkg::*;
(
    input  logic [NUM_BANKS-1:0] req,
    input  logic [BANKS_LEN-1:0] ptr,
    output logic                 valid,
    output logic [BANKS_LEN-1:0] idx
);

    logic [BANKS_LEN-1:0] cand;

    // Scan from the farthest offset down to ptr+1 so the nearest requester wins last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = NUM_BANKS; i >= 1; i--) begin
            cand = ptr + BANKS_LEN'(i);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/cache_ram_arbiter.sv
// Arbitrates several cache banks onto one RAM port. A bank keeps the RAM for
// as long as it holds REN or WEN (so a block pull can roll straight into a
// victim eject), then one idle cycle separates it from the next grant.
//
// Handshake: a bank holds REN/WEN (with addr/store stable) until it sees
// bank_complete for that transfer; bank_complete is ram_complete steered to the
// owning bank. Dropping both REN and WEN while owning releases the RAM.
module cache_ram_arbiter
    import cache_types_pkg::*;
(
    input  logic                                    CLK,
    input  logic                                    nRST,
    input  logic [NUM_BANKS-1:0]                    bank_REN,
    input  logic [NUM_BANKS-1:0]                    bank_WEN,
    input  logic [NUM_BANKS-1:0][31:0]              bank_addr,
    input  logic [NUM_BANKS-1:0][CACHE_RW_SIZE-1:0] bank_store,
    output logic [CACHE_RW_SIZE-1:0]                bank_load,
    output logic [NUM_BANKS-1:0]                    bank_complete,
    output logic                                    ram_REN,
    output logic                                    ram_WEN,
    output logic [31:0]                             ram_addr,
    output logic [CACHE_RW_SIZE-1:0]                ram_store,
    input  logic [CACHE_RW_SIZE-1:0]                ram_load,
    input  logic                                    ram_complete,
    output logic                                    grant_valid,
    output logic [BANKS_LEN-1:0]                    grant_id,
    output logic                                    protocol_err
);

    arb_state_t           state, state_next;
    logic [BANKS_LEN-1:0] grant_q, grant_next;
    logic [BANKS_LEN-1:0] rr_ptr, rr_ptr_next;
    logic                 pick_valid;
    logic [BANKS_LEN-1:0] pick_idx;
    logic                 g_ren, g_wen;
    logic                 err_raw;

    rr_picker u_picker (
        .req   (bank_REN | bank_WEN),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign g_ren     = bank_REN[grant_q];
    assign g_wen     = bank_WEN[grant_q];
    assign grant_id  = grant_q;
    assign bank_load = ram_load;
    // A stray ram_complete while reset is held is not a protocol event.
    assign protocol_err = err_raw & nRST;

    // State, grant and round-robin pointer registers; reset gives bank 0 first priority.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= ARB_IDLE;
            grant_q <= '0;
            rr_ptr  <= BANKS_LEN'(NUM_BANKS - 1);
        end else begin
            state   <= state_next;
            grant_q <= grant_next;
            rr_ptr  <= rr_ptr_next;
        end
    end

    // Next-state logic and RAM/bank steering for the owning bank.
    always_comb begin
        state_next    = state;
        grant_next    = grant_q;
        rr_ptr_next   = rr_ptr;
        ram_REN       = 1'b0;
        ram_WEN       = 1'b0;
        ram_addr      = '0;
        ram_store     = '0;
        bank_complete = '0;
        grant_valid   = 1'b0;
        err_raw       = 1'b0;
        case (state)
            ARB_IDLE: begin
                err_raw = ram_complete;
                if (pick_valid) begin
                    grant_next = pick_idx;
                    state_next = ARB_OWNED;
                end
            end
            ARB_OWNED: begin
                if (g_ren || g_wen) begin
                    grant_valid            = 1'b1;
                    ram_REN                = g_ren;
                    // Read wins when both are raised; the write is dropped and flagged.
                    ram_WEN                = g_wen & ~g_ren;
                    ram_addr               = bank_addr[grant_q];
                    ram_store              = bank_store[grant_q];
                    bank_complete[grant_q] = ram_complete;
                    err_raw                = g_ren & g_wen;
                end else begin
                    // Release cycle: RAM quiet, remember the owner for fairness.
                    err_raw     = ram_complete;
                    rr_ptr_next = grant_q;
                    state_next  = ARB_IDLE;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_ram_arbiter.sv
// Directed bench for cache_ram_arbiter: inputs change 1ns after a rising edge,
// outputs are sampled on the falling edge of the same cycle.
module tb_cache_ram_arbiter;
    import cache_types_pkg::*;

    logic                                    CLK;
    logic                                    nRST;
    logic [NUM_BANKS-1:0]                    bank_REN;
    logic [NUM_BANKS-1:0]                    bank_WEN;
    logic [NUM_BANKS-1:0][31:0]              bank_addr;
    logic [NUM_BANKS-1:0][CACHE_RW_SIZE-1:0] bank_store;
    logic [CACHE_RW_SIZE-1:0]                bank_load;
    logic [NUM_BANKS-1:0]                    bank_complete;
    logic                                    ram_REN;
    logic                                    ram_WEN;
    logic [31:0]                             ram_addr;
    logic [CACHE_RW_SIZE-1:0]                ram_store;
    logic [CACHE_RW_SIZE-1:0]                ram_load;
    logic                                    ram_complete;
    logic                                    grant_valid;
    logic [BANKS_LEN-1:0]                    grant_id;
    logic                                    protocol_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // {grant_valid, grant_id, ram_REN, ram_WEN, bank_complete, protocol_err}
    logic [9:0] stat;
    assign stat = {grant_valid, grant_id, ram_REN, ram_WEN, bank_complete, protocol_err};

    cache_ram_arbiter dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .bank_REN      (bank_REN),
        .bank_WEN      (bank_WEN),
        .bank_addr     (bank_addr),
        .bank_store    (bank_store),
        .bank_load     (bank_load),
        .bank_complete (bank_complete),
        .ram_REN       (ram_REN),
        .ram_WEN       (ram_WEN),
        .ram_addr      (ram_addr),
        .ram_store     (ram_store),
        .ram_load      (ram_load),
        .ram_complete  (ram_complete),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .protocol_err  (protocol_err)
    );

    // Clock and watchdog
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        bank_REN     = '0;
        bank_WEN     = '0;
        bank_addr    = '0;
        bank_store   = '0;
        ram_load     = '0;
        ram_complete = 1'b0;
    endtask

    task automatic reset_dut();
        tick();
        nRST = 1'b0;
        clear_inputs();
        tick();
        nRST = 1'b1;
    endtask

    // Reset values, including asynchronous assertion before any clock edge
    task automatic test_reset();
        nRST = 1'b0;
        clear_inputs();
        ram_load = 32'hA5A5_5A5A;
        #3;
        total_cnt++;
        if (stat !== 10'b0) $display("FAIL reset_async_stat: got %b expected %b", stat, 10'b0);
        else pass_cnt++;
        total_cnt++;
        if (bank_load !== 32'hA5A5_5A5A) $display("FAIL reset_bank_load: got %h expected %h", bank_load, 32'hA5A5_5A5A);
        else pass_cnt++;
        tick();
        tick();
        nRST = 1'b1;
        mid();
        total_cnt++;
        if (stat !== 10'b0 || ram_addr !== 32'h0 || ram_store !== '0)
            $display("FAIL reset_after_release: got stat=%b addr=%h expected stat=0 addr=0", stat, ram_addr);
        else pass_cnt++;
    endtask

    // Bank 0 does four reads with ram_complete every cycle, then drops REN
    task automatic test_single_burst();
        logic [31:0] exp_addr;
        tick();
        bank_REN     = 4'b0001;
        bank_addr[0] = 32'h40;
        mid();
        total_cnt++;
        if (stat !== 10'b0) $display("FAIL single_cycle0_idle: got %b expected %b", stat, 10'b0);
        else pass_cnt++;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_addr     = 32'h40 + 32'(4 * k);
            bank_addr[0] = exp_addr;
            ram_complete = 1'b1;
            ram_load     = 32'h1000 + 32'(k);
            mid();
            total_cnt++;
            if (stat !== {1'b1, 2'd0, 1'b1, 1'b0, 4'b0001, 1'b0})
                $display("FAIL single_read%0d_stat: got %b expected %b", k, stat, {1'b1, 2'd0, 1'b1, 1'b0, 4'b0001, 1'b0});
            else pass_cnt++;
            total_cnt++;
            if (ram_addr !== exp_addr || bank_load !== 32'h1000 + 32'(k))
                $display("FAIL single_read%0d_data: got addr=%h load=%h expected addr=%h load=%h",
                         k, ram_addr, bank_load, exp_addr, 32'h1000 + 32'(k));
            else pass_cnt++;
        end
        tick();
        bank_REN     = '0;
        ram_complete = 1'b0;
        mid();
        total_cnt++;
        if (stat !== 10'b0) $display("FAIL single_release: got %b expected %b", stat, 10'b0);
        else pass_cnt++;
        tick();
        mid();
        total_cnt++;
        if (stat !== 10'b0) $display("FAIL single_idle_after: got %b expected %b", stat, 10'b0);
        else pass_cnt++;
    endtask

    // Banks 1 and 2 request together; bank 1 first, bank 2 after one idle cycle
    task automatic test_contention();
        reset_dut();
        bank_REN = 4'b0110;
        mid();
        total_cnt++;
        if (stat !== 10'b0) $display("FAIL contend_request_idle: got %b expected %b", stat, 10'b0);
        else pass_cnt++;
        tick();
        ram_complete = 1'b1;
        mid();
        total_cnt++;
        if (stat !== {1'b1, 2'd1, 1'b1, 1'b0, 4'b0010, 1'b0})
            $display("FAIL contend_bank1_owns: got %b expected %b", stat, {1'b1, 2'd1, 1'b1, 1'b0, 4'b0010, 1'b0});
        else pass_cnt++;
        tick();
        bank_REN     = 4'b0100;
        ram_complete = 1'b0;
        mid();
        total_cnt++;
        if (stat !== {1'b0, 2'd1, 1'b0, 1'b0, 4'b0000, 1'b0})
            $display("FAIL contend_bank1_release: got %b expected %b", stat, {1'b0, 2'd1, 1'b0, 1'b0, 4'b0000, 1'b0});
        else pass_cnt++;
        tick();
        mid();
        total_cnt++;
        if (stat !== {1'b0, 2'd1, 1'b0, 1'b0, 4'b0000, 1'b0})
            $display("FAIL contend_idle_gap: got %b expected %b", stat, {1'b0, 2'd1, 1'b0, 1'b0, 4'b0000, 1'b0});
        else pass_cnt++;
        tick();
        ram_complete = 1'b1;
        mid();
        total_cnt++;
        if (stat !== {1'b1, 2'd2, 1'b1, 1'b0, 4'b0100, 1'b0})
            $display("FAIL contend_bank2_owns: got %b expected %b", stat, {1'b1, 2'd2, 1'b1, 1'b0, 4'b0100, 1'b0});
        else pass_cnt++;
        tick();
        bank_REN     = '0;
        ram_complete = 1'b0;
        tick();
    endtask

    // Bank 3 pulls four words then ejects four words under one grant
    task automatic test_back_to_back();
        logic        ren, wen;
        logic [31:0] exp_addr;
        bank_store[0] = 32'hBAD0_0000;
        bank_store[1] = 32'hBAD1_1111;
        bank_store[2] = 32'hBAD2_2222;
        tick();
        bank_REN     = 4'b1000;
        bank_addr[3] = 32'h100;
        mid();
        total_cnt++;
        if (stat !== {1'b0, 2'd2, 1'b0, 1'b0, 4'b0000, 1'b0})
            $display("FAIL b2b_request_idle: got %b expected %b", stat, {1'b0, 2'd2, 1'b0, 1'b0, 4'b0000, 1'b0});
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            tick();
            ren           = (k < 4);
            wen           = (k >= 4);
            exp_addr      = 32'h100 + 32'(4 * (k % 4));
            bank_REN[3]   = ren;
            bank_WEN[3]   = wen;
            bank_addr[3]  = exp_addr;
            bank_store[3] = 32'hD000_0000 + 32'(k);
            ram_complete  = 1'b1;
            mid();
            total_cnt++;
            if (stat !== {1'b1, 2'd3, ren, wen, 4'b1000, 1'b0})
                $display("FAIL b2b_xfer%0d_stat: got %b expected %b", k, stat, {1'b1, 2'd3, ren, wen, 4'b1000, 1'b0});
            else pass_cnt++;
            total_cnt++;
            if (ram_addr !== exp_addr || ram_store !== 32'hD000_0000 + 32'(k))
                $display("FAIL b2b_xfer%0d_data: got addr=%h store=%h expected addr=%h store=%h",
                         k, ram_addr, ram_store, exp_addr, 32'hD000_0000 + 32'(k));
            else pass_cnt++;
        end
        tick();
        bank_REN     = '0;
        bank_WEN     = '0;
        ram_complete = 1'b0;
        mid();
        total_cnt++;
        if (stat !== {1'b0, 2'd3, 1'b0, 1'b0, 4'b0000, 1'b0})
            $display("FAIL b2b_release: got %b expected %b", stat, {1'b0, 2'd3, 1'b0, 1'b0, 4'b0000, 1'b0});
        else pass_cnt++;
        tick();
    endtask

    // All four banks request; each releases after one transfer
    task automatic test_round_robin();
        logic [1:0] e;
        logic [3:0] onehot;
        reset_dut();
        for (int b = 0; b < NUM_BANKS; b++) bank_addr[b] = 32'h200 + 32'(16 * b);
        bank_REN = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            e      = 2'(n % 4);
            onehot = 4'b0001 << e;
            tick();
            ram_complete = 1'b1;
            mid();
            total_cnt++;
            if (stat !== {1'b1, e, 1'b1, 1'b0, onehot, 1'b0} || ram_addr !== 32'h200 + 32'(16 * e))
                $display("FAIL rr_grant%0d: got stat=%b addr=%h expected stat=%b addr=%h",
                         n, stat, ram_addr, {1'b1, e, 1'b1, 1'b0, onehot, 1'b0}, 32'h200 + 32'(16 * e));
            else pass_cnt++;
            tick();
            ram_complete = 1'b0;
            bank_REN[e]  = 1'b0;
            mid();
            total_cnt++;
            if (stat !== {1'b0, e, 1'b0, 1'b0, 4'b0000, 1'b0})
                $display("FAIL rr_release%0d: got %b expected %b", n, stat, {1'b0, e, 1'b0, 1'b0, 4'b0000, 1'b0});
            else pass_cnt++;
            tick();
            bank_REN[e] = 1'b1;
        end
        tick();
        bank_REN = '0;
        tick();
        tick();
    endtask

    // REN+WEN together, then stray completes in release and idle cycles
    task automatic test_protocol_err();
        reset_dut();
        bank_REN = 4'b0001;
        tick();
        mid();
        total_cnt++;
        if (stat !== {1'b1, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b0})
            $display("FAIL perr_clean_read: got %b expected %b", stat, {1'b1, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b0});
        else pass_cnt++;
        tick();
        bank_WEN = 4'b0001;
        mid();
        total_cnt++;
        if (stat !== {1'b1, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b1})
            $display("FAIL perr_ren_wen: got %b expected %b", stat, {1'b1, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b1});
        else pass_cnt++;
        tick();
        bank_WEN = '0;
        mid();
        total_cnt++;
        if (protocol_err !== 1'b0) $display("FAIL perr_clears: got %b expected 0", protocol_err);
        else pass_cnt++;
        tick();
        bank_REN     = '0;
        ram_complete = 1'b1;
        mid();
        total_cnt++;
        if (stat !== {1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1})
            $display("FAIL perr_release_stray: got %b expected %b", stat, {1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1});
        else pass_cnt++;
        tick();
        mid();
        total_cnt++;
        if (stat !== {1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1})
            $display("FAIL perr_idle_stray: got %b expected %b", stat, {1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1});
        else pass_cnt++;
        tick();
        ram_complete = 1'b0;
        mid();
        total_cnt++;
        if (stat !== 10'b0) $display("FAIL perr_quiet_idle: got %b expected %b", stat, 10'b0);
        else pass_cnt++;
    endtask

    // Reset during bank 2's second transfer, then re-grant with 1-cycle latency
    task automatic test_reset_mid_burst();
        reset_dut();
        bank_REN = 4'b0100;
        tick();
        ram_complete = 1'b1;
        mid();
        total_cnt++;
        if (stat !== {1'b1, 2'd2, 1'b1, 1'b0, 4'b0100, 1'b0})
            $display("FAIL rst_mid_xfer1: got %b expected %b", stat, {1'b1, 2'd2, 1'b1, 1'b0, 4'b0100, 1'b0});
        else pass_cnt++;
        tick();
        mid();
        nRST = 1'b0;
        #1;
        total_cnt++;
        if (stat !== 10'b0) $display("FAIL rst_mid_async_drop: got %b expected %b", stat, 10'b0);
        else pass_cnt++;
        ram_complete = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
        mid();
        total_cnt++;
        if (stat !== 10'b0) $display("FAIL rst_mid_first_idle: got %b expected %b", stat, 10'b0);
        else pass_cnt++;
        tick();
        mid();
        total_cnt++;
        if (stat !== {1'b1, 2'd2, 1'b1, 1'b0, 4'b0000, 1'b0})
            $display("FAIL rst_mid_regrant: got %b expected %b", stat, {1'b1, 2'd2, 1'b1, 1'b0, 4'b0000, 1'b0});
        else pass_cnt++;
        tick();
        bank_REN = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_contention();
        test_back_to_back();
        test_round_robin();
        test_protocol_err();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
